// File: rtl/div_sigcalc_seq.sv
// Sequential radix-2 restoring significand divider with start/done handshake.
// Optional DIV_SEQ_EARLY_TERM_EN: finish as soon as the partial remainder is zero.
module div_sigcalc_seq #(
    parameter int sig_width = 23
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [sig_width:0]   x,
    input  logic [sig_width:0]   d,
    output logic                 busy,
    output logic                 done,
    output logic [sig_width:0]   quotient,
    output logic                 guard_bit,
    output logic                 round_bit,
    output logic                 sticky_bit,
    output logic                 count
);
    localparam int N  = sig_width + 3;
    localparam int RW = sig_width + 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t               state, state_nxt;
    logic [sig_width:0]   d_r;
    logic                 count_r;
    logic [RW-1:0]        rem;
    logic [N-1:0]         q;
    logic [CW-1:0]        cnt;

    logic                 accept;
    logic                 ge;
    logic                 last;
    logic [RW-1:0]        rem_sub;
    logic [N-1:0]         q_step;
    logic [N-1:0]         q_fin;

    assign accept = (state != ITER) && start;

    always_comb begin
        ge      = rem >= {1'b0, d_r};
        rem_sub = ge ? (rem - {1'b0, d_r}) : rem;
        q_step  = {q[N-2:0], ge};
`ifdef DIV_SEQ_EARLY_TERM_EN
        // A zero remainder means every remaining quotient bit is zero.
        last  = (cnt == CW'(1)) || (rem_sub == '0);
        q_fin = q_step << (cnt - CW'(1));
`else
        last  = (cnt == CW'(1));
        q_fin = q_step;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ITER;
            ITER:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? ITER : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ITER);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_r        <= '0;
            count_r    <= 1'b0;
            rem        <= '0;
            q          <= '0;
            cnt        <= '0;
            quotient   <= '0;
            guard_bit  <= 1'b0;
            round_bit  <= 1'b0;
            sticky_bit <= 1'b0;
            count      <= 1'b0;
        end else if (accept) begin
            d_r     <= d;
            count_r <= (x < d);
            // Pre-shift the dividend when x < d so the quotient MSB lands at 1.
            rem     <= (x < d) ? {x, 1'b0} : {1'b0, x};
            q       <= '0;
            cnt     <= CW'(N);
        end else if (state == ITER) begin
            q   <= q_step;
            rem <= {rem_sub[RW-2:0], 1'b0};
            cnt <= cnt - CW'(1);
            if (last) begin
                quotient   <= q_fin[N-1:2];
                guard_bit  <= q_fin[1];
                round_bit  <= q_fin[0];
                sticky_bit <= (rem_sub != '0);
                count      <= count_r;
            end
        end
    end
endmodule

// File: doc/div_sigcalc_seq.md
# div_sigcalc_seq

Sequential radix-2 restoring significand divider for the floating-point divide datapath. Takes two normalised significands (hidden bit included) and produces the normalised quotient plus guard, round and sticky bits and the normalisation flag `count`. The exponent subtraction and `round_mac_div` rounding stage consume these outputs. It is the iterative, low-area alternative to the combinational/pipelined `div_sigcalc`, using a start/done handshake.

## Interface
- `sig_width`, 23, stored fraction width. Operands and quotient are `sig_width+1` bits.
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  request. Sampled only in IDLE or DONE.
- `x`  in  sig_width+1  dividend significand. MSB must be 1.
- `d`  in  sig_width+1  divisor significand. MSB must be 1.
- `busy`  out  1  high while in ITER
- `done`  out  1  high for exactly one cycle (DONE state)
- `quotient`  out  sig_width+1  normalised quotient. MSB is always 1.
- `guard_bit`, `round_bit`, `sticky_bit`  out  1 each  rounding bits
- `count`  out  1  1 when x < d (quotient pre-shifted by one; exponent decremented downstream)

## Operation
- N = sig_width+3 iterations. Internal quotient shift register q is N bits. Remainder R is sig_width+2 bits. Down-counter is ceil(log2(N+1)) bits.
- States: IDLE, ITER, DONE.
- **Accept:** accept occurs in IDLE or DONE with start=1.
  - Latch d.
  - Set count_r = (x < d).
  - Set R = count_r ? {x,1'b0} : {1'b0,x}.
  - Clear q. Load counter with N. Go to ITER.
- **ITER, each cycle:**
  - If R >= d: q = {q[N-2:0],1}, R' = R-d. Otherwise q = {q[N-2:0],0}, R' = R.
  - Then R = R'<<1 (MSB discarded; never set, since R' < d).
  - Decrement counter. When counter reaches 1 in this cycle, go to DONE.
- **DONE:**
  - quotient = q[N-1:2], guard_bit = q[1], round_bit = q[0], sticky_bit = (R != 0), count = count_r.
  - These outputs are registered at the DONE transition and held until the next DONE transition.
  - Next state is ITER if start=1, otherwise IDLE.
- start in ITER is ignored. It is not queued.
- Operands with MSB=0 are out of contract; outputs are unspecified but the FSM still terminates. d=0 cannot occur.
- Reset at any time: state IDLE, q, R, counter and all outputs 0. An in-flight operation is discarded with no done pulse.

## Timing
- Edge E0 samples start. ITER is active on edges E1..EN. done=1 in the cycle after EN. Start-to-done latency is N cycles (26 for sig_width=23).
- busy=1 from after E0 until after EN.
- Back-to-back: start held high gives one result every N+1 cycles.
- Result outputs change only on the edge entering DONE, and are stable when done=1.
- Reset values: busy=0, done=0, quotient=0, guard_bit=round_bit=sticky_bit=0, count=0.

## Configuration
- `DIV_SEQ_EARLY_TERM_EN`
  - **Defined:** if R' == 0 after any iteration, the FSM goes to DONE on that edge. The remaining q positions are zero-filled (q shifted left by the remaining count), and sticky_bit = 0. Latency is variable, from 1 to N cycles. Results are bit-identical to the undefined case.
  - **Undefined:** the fixed N-cycle latency described above.

## Test plan
- sig_width=23, x=d=0x800000:
  - Result: quotient=0x800000, g=r=s=0, count=0.
  - done at 26 cycles. With `DIV_SEQ_EARLY_TERM_EN`, done at 1 cycle.
- x=0xC00000, d=0x800000 → quotient=0xC00000, g=r=s=0, count=0.
- x=0x800000, d=0xC00000 → quotient=0xAAAAAA, guard=1, round=0, sticky=1, count=1. done at 26 cycles in both configurations.
- start pulsed again at cycle 10 of an operation:
  - The pulse is ignored.
  - Exactly one done, at cycle 26, with the first operation's result.
- start held high across two operands → two done pulses 27 cycles apart, with correct results each.
- resetn low at cycle 12, released at 14:
  - All outputs 0 and no done.
  - A new start then completes normally.
